// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch looks up if_pc combinationally every cycle; execute writes resolved
// control-transfer outcomes back on the rising edge.
// Optional build macro: BTB_PERF_EN adds perf_updates / perf_mispredicts
// event counters (ex_mispredict is only consumed when it is defined).
//
// Update handshake: ex_upd_valid is a one-cycle strobe with no ready
// back-pressure; the table accepts every strobe seen on a rising edge while
// rst is high, so ex_pc/ex_is_jump/ex_taken/ex_target/ex_mispredict only
// need to be stable around that edge.
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        btb_hit,
    output logic        pred_taken,
    output logic [31:0] btb_pc,
    input  logic        ex_upd_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_jump,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_mispredict
`ifdef BTB_PERF_EN
    ,
    output logic [31:0] perf_updates,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    logic             upd_we;
    logic [31:0]      upd_target;
    logic [1:0]       upd_ctr;

    // The low two PC bits never select anything (instructions are word aligned).
    wire unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};
`ifndef BTB_PERF_EN
    wire unused_mispredict = ex_mispredict;
`endif

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Lookup reads the stored table only, so a same-cycle update is not bypassed.
    always_comb begin
        btb_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken = btb_hit && ctr_q[lk_idx][1];
        btb_pc     = pred_taken ? target_q[lk_idx] : 32'h0;
    end

    // Decide whether and what to write into the entry addressed by ex_pc.
    always_comb begin
        upd_we     = 1'b0;
        upd_target = target_q[ex_idx];
        upd_ctr    = ctr_q[ex_idx];
        if (ex_upd_valid) begin
            if (ex_is_jump) begin
                // Unconditional transfers are always strongly taken.
                upd_we     = 1'b1;
                upd_target = ex_target;
                upd_ctr    = 2'b11;
            end else if (ex_hit) begin
                upd_we = 1'b1;
                if (ex_taken) begin
                    upd_target = ex_target;
                    upd_ctr    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                end else begin
                    upd_ctr    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else if (ex_taken) begin
                // New taken branch starts weakly taken; a not-taken miss is not worth a slot.
                upd_we     = 1'b1;
                upd_target = ex_target;
                upd_ctr    = 2'b10;
            end
        end
    end

    // Table storage: cleared asynchronously, one entry written per edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (upd_we) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= upd_target;
            ctr_q[ex_idx]    <= upd_ctr;
        end
    end

`ifdef BTB_PERF_EN
    // Free-running event counters that wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_updates     <= 32'h0;
            perf_mispredicts <= 32'h0;
        end else if (ex_upd_valid) begin
            perf_updates <= perf_updates + 32'h1;
            if (ex_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'h1;
            end
        end
    end
`endif

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV32I pipeline. Fetch queries it every cycle with the current PC. On a predicted-taken hit it supplies the target that fetch control steers through the `pcmux::btb_pc` leg. Execute writes back resolved branch/jump outcomes; fetch control uses `br_out` / `ex_pc_plus4` to recover from mispredictions.

## Interface
- `ENTRIES`, 16, number of entries; power of two, ≥ 2. `IDX_W = $clog2(ENTRIES)`, `TAG_W = 30 - IDX_W` derived.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_pc` in 32: fetch PC to look up.
- `btb_hit` out 1: valid entry with matching tag for `if_pc`.
- `pred_taken` out 1: `btb_hit` && counter[1].
- `btb_pc` out 32: predicted target; 0 when `pred_taken`=0.
- `ex_upd_valid` in 1: resolved control-transfer instruction in EX this cycle.
- `ex_pc` in 32: PC of the resolved instruction.
- `ex_is_jump` in 1: 1 = JAL/JALR (unconditional), 0 = conditional branch.
- `ex_taken` in 1: actual direction.
- `ex_target` in 32: actual target (bit 0 already cleared by EX for JALR).
- `ex_mispredict` in 1: EX detected a wrong direction or target. Used only under the macro.

## Operation
- Index = `pc[IDX_W+1:2]`; tag = `pc[31:IDX_W+2]`; `pc[1:0]` ignored.
- Per entry: `valid`, `tag[TAG_W]`, `target[32]`, `ctr[2]`.
- Lookup is combinational from the stored table.
  - `btb_hit` = valid && tag match.
  - `pred_taken` = `btb_hit` && `ctr[1]`.
  - `btb_pc` = target when `pred_taken`, else 32'h0.
- Update happens on a rising edge when `ex_upd_valid`=1. Hit means the entry at `ex_pc` is valid with a matching tag.
  - Jump, any hit state: entry written with valid=1, tag, target=`ex_target`, ctr=2'b11.
  - Branch hit, taken: ctr saturating +1 (max 2'b11); target overwritten with `ex_target`.
  - Branch hit, not taken: ctr saturating −1 (min 2'b00); target unchanged; entry stays valid.
  - Branch miss, taken: allocate or replace the entry with valid=1, tag, target, ctr=2'b10.
  - Branch miss, not taken: no write.
- No replacement policy beyond direct mapping; a conflicting tag overwrites the entry.
- `ex_upd_valid`=0: table unchanged regardless of other inputs.

## Timing
- Lookup latency: 0 cycles (same-cycle combinational from `if_pc`).
- Update visible to lookup on the cycle after the writing edge.
- A lookup and an update to the same index in the same cycle: lookup returns pre-update contents. There is no write-through bypass.
- Reset (`rst`=0, asynchronous):
  - all `valid`=0, `ctr`=2'b00, `target`=0, `tag`=0;
  - outputs immediately `btb_hit`=0, `pred_taken`=0, `btb_pc`=0.
- Reset asserted in the same cycle as an update: reset wins; the update is lost.
- Release of `rst` is synchronized externally. The first update is accepted on the first rising edge with `rst`=1.

## Configuration
- `BTB_PERF_EN` defined: adds outputs `perf_updates` out 32 and `perf_mispredicts` out 32.
  - `perf_updates` increments on each edge with `ex_upd_valid`=1.
  - `perf_mispredicts` increments when `ex_upd_valid`=1 && `ex_mispredict`=1.
  - Both wrap 32'hFFFF_FFFF → 0 and are cleared by `rst`.
- `BTB_PERF_EN` undefined: counters and their ports are absent; `ex_mispredict` is ignored.

## Test plan
- Reset, then `if_pc`=0x0000_0040 → `btb_hit`=0, `pred_taken`=0, `btb_pc`=0. Asserting `rst` mid-run with populated entries clears all outputs without a clock edge.
- Taken branch at `ex_pc`=0x100, `ex_target`=0x180 → next cycle `if_pc`=0x100 gives `btb_hit`=1, `pred_taken`=1, `btb_pc`=0x180. Then one not-taken update → ctr 2'b01, `pred_taken`=0, `btb_hit`=1.
- Saturation: five taken updates on 0x100 keep ctr at 2'b11. Four not-taken updates → ctr 2'b00; a further not-taken leaves 2'b00.
- Aliasing with `ENTRIES`=16: allocate 0x100 (target 0x180), then a taken branch at 0x140 (target 0x200) → lookup 0x100 misses, lookup 0x140 hits with 0x200.
- Same-cycle update and lookup: update allocates 0x104 while `if_pc`=0x104 → `btb_hit`=0 that cycle, 1 the next. A not-taken miss at 0x108 never allocates. JALR at 0x10C with target 0x400 → ctr 2'b11, `btb_pc`=0x400.
- With `BTB_PERF_EN`: 10 updates, 3 with `ex_mispredict`=1 → `perf_updates`=10, `perf_mispredicts`=3. Preloading the counter to 32'hFFFF_FFFF, one update wraps it to 0.
